// File: rtl/framed_shift_pkg.sv
// Shared definitions for the framed shift register: FSM state encoding.
package framed_shift_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  // Direction latched while idle and after reset.
  localparam logic DirResetMsbFirst = 1'b1;

endpackage

// File: rtl/shift_bitcounter.sv
// Loadable down-counter tracking bits remaining in a frame; flags the decrement that reaches zero.
module shift_bitcounter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  // High on the decrement that takes the count from 1 to 0.
  assign zero_o = dec_i && !load_i && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/framed_shiftregister.sv
// Framed bidirectional shift register: loads a word, shifts WIDTH bits on peripheral strobes,
// then publishes the received word with a one-cycle frameDone pulse.
module framed_shiftregister
  import framed_shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             peripheralClkEdge,
  input  logic             msbFirst,
  input  logic             loadValid,
  output logic             loadReady,
  input  logic [WIDTH-1:0] parallelDataIn,
  input  logic             serialDataIn,
  output logic             serialDataOut,
  output logic [WIDTH-1:0] parallelDataOut,
  output logic             frameDone,
  output logic             busy
);

  state_e state_q, state_d;

  logic [WIDTH-1:0] mem_q, mem_d;
  logic [WIDTH-1:0] par_out_q, par_out_d;
  logic             msb_first_q, msb_first_d;
  logic             frame_done_q, frame_done_d;

  logic             load_en;
  logic             shift_en;
  logic             last_shift;
  logic [CNT_W-1:0] cnt;

  assign load_en  = (state_q == StIdle) && loadValid;
  assign shift_en = (state_q == StShift) && peripheralClkEdge;

  shift_bitcounter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk_i      (clk),
    .rst_i      (reset),
    .load_i     (load_en),
    .load_val_i (CNT_W'(WIDTH)),
    .dec_i      (shift_en),
    .cnt_o      (cnt),
    .zero_o     (last_shift)
  );

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (loadValid) state_d = StShift;
      StShift: if (last_shift) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    loadReady = (state_q == StIdle);
    busy      = !loadReady;
  end

  always_comb begin
    mem_d        = mem_q;
    msb_first_d  = msb_first_q;
    par_out_d    = par_out_q;
    frame_done_d = 1'b0;
    if (load_en) begin
      mem_d       = parallelDataIn;
      msb_first_d = msbFirst;
    end else if (shift_en) begin
      if (msb_first_q) begin
        mem_d = {mem_q[WIDTH-2:0], serialDataIn};
      end else begin
        mem_d = {serialDataIn, mem_q[WIDTH-1:1]};
      end
    end
    // Publish the word including the final bit shifted on this edge.
    if (last_shift) begin
      par_out_d    = mem_d;
      frame_done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q        <= '0;
      msb_first_q  <= DirResetMsbFirst;
      par_out_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      msb_first_q  <= msb_first_d;
      par_out_q    <= par_out_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign serialDataOut   = msb_first_q ? mem_q[WIDTH-1] : mem_q[0];
  assign parallelDataOut = par_out_q;
  assign frameDone       = frame_done_q;

endmodule
